// File: rtl/ovf_writeback_stage_pkg.sv
// Shared constants and payload types for the overflow-aware writeback stage.
package ovf_writeback_stage_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;

  localparam logic [1:0] RSTATUS_ADD  = 2'd1;
  localparam logic [1:0] RSTATUS_ADDI = 2'd2;
  localparam logic [1:0] RSTATUS_SUB  = 2'd3;

  localparam int unsigned STATUS_REG_DEF = 30;
  localparam int unsigned REG_W          = 5;

  // Classified register-file write metadata, stored alongside the data word.
  typedef struct packed {
    logic             needs_write;
    logic [REG_W-1:0] wreg;
  } wb_meta_t;

  localparam int unsigned META_W = $bits(wb_meta_t);

endpackage

// File: rtl/ovf_writeback_stage_wb_fifo2.sv
// Two-entry in-order FIFO whose head entry sits in its own register.
module wb_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             head_valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A push into a full buffer is dropped; the producer is expected to honour ready.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push_i) begin
          head_d  = data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop_i) begin
          head_d = data_i;
        end else if (push_i) begin
          tail_d  = data_i;
          count_d = 2'd2;
        end else if (pop_i) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop_i) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  assign head_o       = head_q;
  assign head_valid_o = (count_q != 2'd0);
  assign count_o      = count_q;

endmodule

// File: rtl/ovf_writeback_stage.sv
// Writeback stage: classifies execute results into normal or status-register writes,
// buffers them two deep against a busy write port, and tracks overflow events.
module ovf_writeback_stage
  import ovf_writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned STATUS_REG = STATUS_REG_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              overflow,
  input  logic              check_ovf,
  input  logic [1:0]        rstatus,
  input  logic              rf_ready,
  output logic              ctrl_writeEnable,
  output logic [4:0]        ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  input  logic              clear_status,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int unsigned ENTRY_W = META_W + DATA_W;

  logic               exc_c;
  logic               push_c;
  logic               pop_c;
  wb_meta_t           push_meta_c;
  logic [DATA_W-1:0]  push_data_c;
  logic [ENTRY_W-1:0] head_entry;
  wb_meta_t           head_meta;
  logic               head_valid;
  logic [1:0]         fifo_count;

  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Decide the register-file write at push time so the buffer holds final writes.
  always_comb begin
    exc_c       = check_ovf & overflow;
    push_meta_c = '0;
    push_data_c = '0;
    if (exc_c) begin
      push_meta_c.needs_write = 1'b1;
      push_meta_c.wreg        = REG_W'(STATUS_REG);
      push_data_c             = DATA_W'(rstatus);
    end else if ((opcode == OP_RTYPE) || (opcode == OP_ADDI)) begin
      push_meta_c.needs_write = (rd != 5'd0);
      push_meta_c.wreg        = rd;
      push_data_c             = alu_result;
    end
  end

  assign in_ready = (fifo_count < 2'd2);
  assign push_c   = in_valid & in_ready;
  assign pop_c    = head_valid & (rf_ready | ~head_meta.needs_write);

  wb_fifo2 #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .data_i      ({push_meta_c, push_data_c}),
    .head_o      (head_entry),
    .head_valid_o(head_valid),
    .count_o     (fifo_count)
  );

  assign head_meta        = wb_meta_t'(head_entry[ENTRY_W-1:DATA_W]);
  assign ctrl_writeEnable = head_valid & head_meta.needs_write;
  assign ctrl_writeReg    = head_meta.wreg;
  assign data_writeReg    = head_entry[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // An overflow event in the same cycle as a clear restarts the count at one.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (push_c && exc_c) begin
      sticky_d = 1'b1;
      if (clear_status) begin
        cnt_d = CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clear_status) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  assign ovf_sticky = sticky_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_ovf_writeback_stage.sv
// Directed bench for ovf_writeback_stage; a second instance uses a 2-bit counter for saturation.
module tb_ovf_writeback_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic        overflow;
  logic        check_ovf;
  logic [1:0]  rstatus;
  logic        rf_ready;
  logic        clear_status;

  logic        in_ready,  in_ready2;
  logic        we,        we2;
  logic [4:0]  wreg,      wreg2;
  logic [31:0] wdata,     wdata2;
  logic        sticky,    sticky2;
  logic [7:0]  cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  ovf_writeback_stage u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .alu_result(alu_result), .overflow(overflow),
    .check_ovf(check_ovf), .rstatus(rstatus), .rf_ready(rf_ready),
    .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata),
    .clear_status(clear_status), .ovf_sticky(sticky), .ovf_count(cnt)
  );

  ovf_writeback_stage #(.CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .rd(rd), .alu_result(alu_result), .overflow(overflow),
    .check_ovf(check_ovf), .rstatus(rstatus), .rf_ready(rf_ready),
    .ctrl_writeEnable(we2), .ctrl_writeReg(wreg2), .data_writeReg(wdata2),
    .clear_status(clear_status), .ovf_sticky(sticky2), .ovf_count(cnt2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] r,
                       input logic [31:0] d, input logic ov, input logic ck, input logic [1:0] st);
    in_valid   = v;
    opcode     = op;
    rd         = r;
    alu_result = d;
    overflow   = ov;
    check_ovf  = ck;
    rstatus    = st;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    reset        = 1'b0;
    rf_ready     = 1'b1;
    clear_status = 1'b0;
    idle();
    step();
    step();
    chk("rst_we",     32'(we),       32'd0);
    chk("rst_wreg",   32'(wreg),     32'd0);
    chk("rst_wdata",  wdata,         32'd0);
    chk("rst_sticky", 32'(sticky),   32'd0);
    chk("rst_count",  32'(cnt),      32'd0);
    reset = 1'b1;
    step();
    chk("rst_ready",  32'(in_ready), 32'd1);

    // normal add to r5
    drive(1'b1, 5'b00000, 5'd5, 32'h7, 1'b0, 1'b0, 2'd1);
    step();
    idle();
    chk("add_we",    32'(we),   32'd1);
    chk("add_wreg",  32'(wreg), 32'd5);
    chk("add_wdata", wdata,     32'h7);
    step();
    chk("add_we_one_cycle", 32'(we), 32'd0);

    // qualified overflow on sub redirects to r30
    drive(1'b1, 5'b00000, 5'd4, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd3);
    step();
    idle();
    chk("ovf_we",     32'(we),     32'd1);
    chk("ovf_wreg",   32'(wreg),   32'd30);
    chk("ovf_wdata",  wdata,       32'h3);
    chk("ovf_sticky", 32'(sticky), 32'd1);
    chk("ovf_count",  32'(cnt),    32'd1);
    step();
    chk("ovf_drained", 32'(we),    32'd0);

    // raw overflow without qualification stays a normal addi write
    drive(1'b1, 5'b00101, 5'd6, 32'h8000_0000, 1'b1, 1'b0, 2'd2);
    step();
    idle();
    chk("unq_wreg",  32'(wreg), 32'd6);
    chk("unq_wdata", wdata,     32'h8000_0000);
    chk("unq_count", 32'(cnt),  32'd1);
    step();

    // back-pressure: three results against a busy port
    rf_ready = 1'b0;
    drive(1'b1, 5'b00000, 5'd1, 32'h11, 1'b0, 1'b0, 2'd0);
    step();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    chk("bp_head1",  32'(wreg),     32'd1);
    drive(1'b1, 5'b00000, 5'd2, 32'h22, 1'b0, 1'b0, 2'd0);
    step();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    drive(1'b1, 5'b00000, 5'd3, 32'h33, 1'b0, 1'b0, 2'd0);
    step();
    chk("bp_hold_we",    32'(we),       32'd1);
    chk("bp_hold_wreg",  32'(wreg),     32'd1);
    chk("bp_hold_wdata", wdata,         32'h11);
    chk("bp_still_full", 32'(in_ready), 32'd0);
    rf_ready = 1'b1;
    step();
    chk("bp_ret2_wreg",  32'(wreg),     32'd2);
    chk("bp_ret2_wdata", wdata,         32'h22);
    chk("bp_ret2_ready", 32'(in_ready), 32'd1);
    step();
    idle();
    chk("bp_ret3_wreg",  32'(wreg), 32'd3);
    chk("bp_ret3_wdata", wdata,     32'h33);
    chk("bp_ret3_we",    32'(we),   32'd1);
    step();
    chk("bp_empty_we",   32'(we),   32'd0);

    // suppressed writes drain even while the port is busy
    rf_ready = 1'b0;
    drive(1'b1, 5'b00000, 5'd0, 32'h55, 1'b0, 1'b0, 2'd0);
    step();
    chk("sup_rd0_we",    32'(we),       32'd0);
    drive(1'b1, 5'b01000, 5'd7, 32'h66, 1'b0, 1'b0, 2'd0);
    step();
    chk("sup_op_we",     32'(we),       32'd0);
    chk("sup_op_ready",  32'(in_ready), 32'd1);
    drive(1'b1, 5'b00000, 5'd9, 32'h99, 1'b0, 1'b0, 2'd0);
    step();
    idle();
    chk("sup_next_we",    32'(we),       32'd1);
    chk("sup_next_wreg",  32'(wreg),     32'd9);
    chk("sup_next_ready", 32'(in_ready), 32'd1);
    rf_ready = 1'b1;
    step();
    chk("sup_done_we",    32'(we),       32'd0);

    // reset while full and stalled
    rf_ready = 1'b0;
    drive(1'b1, 5'b00000, 5'd2, 32'h1, 1'b1, 1'b1, 2'd1);
    step();
    drive(1'b1, 5'b00000, 5'd3, 32'h2, 1'b0, 1'b0, 2'd0);
    step();
    idle();
    chk("mid_full",  32'(in_ready), 32'd0);
    chk("mid_count", 32'(cnt),      32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_we",    32'(we),     32'd0);
    chk("mid_rst_wreg",  32'(wreg),   32'd0);
    chk("mid_rst_wdata", wdata,       32'd0);
    chk("mid_rst_count", 32'(cnt),    32'd0);
    chk("mid_rst_stky",  32'(sticky), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    chk("mid_rel_we",    32'(we),       32'd0);
    rf_ready = 1'b1;
    step();
    chk("mid_no_stale",  32'(we),       32'd0);

    // counter saturation and clear precedence
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'b00000, 5'd8, 32'h0, 1'b1, 1'b1, 2'd1);
      step();
      chk($sformatf("sat_cnt2_%0d", i), 32'(cnt2), (i > 3) ? 32'd3 : 32'(i));
      chk($sformatf("sat_cnt8_%0d", i), 32'(cnt),  32'(i));
    end
    chk("sat_ready", 32'(in_ready2), 32'd1);
    clear_status = 1'b1;
    step();
    idle();
    chk("clr_evt_cnt2",   32'(cnt2),    32'd1);
    chk("clr_evt_sticky", 32'(sticky2), 32'd1);
    chk("clr_evt_cnt8",   32'(cnt),     32'd1);
    step();
    clear_status = 1'b0;
    chk("clr_cnt2",   32'(cnt2),    32'd0);
    chk("clr_sticky", 32'(sticky2), 32'd0);
    chk("clr_cnt8",   32'(cnt),     32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ovf_writeback_stage.md
Name: ovf_writeback_stage

Overview:
- Writeback stage directly downstream of the execute-side overflow checker.
- Consumes the ALU result plus the checker's overflow-qualify flag and 2-bit status code, and decides the register-file write: the normal rd write, or an exception write of the status code to $r30.
- Holds results in a 2-entry buffer so a busy register-file write port back-pressures execute without losing results.
- Also keeps a sticky overflow flag and a saturating overflow event counter for debug/status readout.

Parameters:
- DATA_W, 32, register data width
- CNT_W, 8, width of overflow event counter
- STATUS_REG, 30, register index receiving rstatus on qualified overflow

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  execute result present this cycle
- in_ready  output  1  stage can accept a result this cycle
- opcode  input  5  instruction opcode of the result
- rd  input  5  destination register of the result
- alu_result  input  DATA_W  ALU output
- overflow  input  1  raw ALU overflow
- check_ovf  input  1  overflow is architecturally meaningful for this opcode/ALUop
- rstatus  input  2  status code (add=1, addi=2, sub=3)
- rf_ready  input  1  register-file write port free this cycle
- ctrl_writeEnable  output  1  register-file write strobe
- ctrl_writeReg  output  5  register-file write address
- data_writeReg  output  DATA_W  register-file write data
- clear_status  input  1  clears sticky flag and counter
- ovf_sticky  output  1  a qualified overflow has occurred since last clear
- ovf_count  output  CNT_W  qualified overflow events, saturating

Behaviour:
- Transfer rule: a result transfers when in_valid & in_ready.
- in_ready = (occupancy < 2). It is computed from the current occupancy only; a same-cycle pop does not raise it.
- Classification at push time; the classified write is stored in the buffer:
  - exc = check_ovf & overflow.
  - If exc: target = STATUS_REG, data = zero-extended rstatus, needs_write = 1.
  - Else if opcode is 00000 (R-type) or 00101 (addi): target = rd, data = alu_result, needs_write = (rd != 0).
  - Else: needs_write = 0.
- Buffer: 2-entry FIFO, in-order, with registered head.
  - ctrl_writeEnable = head_valid & head.needs_write. ctrl_writeReg and data_writeReg are driven from the head.
  - Pop conditions: head_valid & (rf_ready | ~head.needs_write). Entries needing no write drain in one cycle regardless of rf_ready.
- Latency: a result pushed in cycle N is earliest visible on the write outputs in cycle N+1 with an empty buffer. The write completes in the first cycle ≥ N+1 with rf_ready=1.
- While a write is presented and rf_ready=0, the write outputs hold stable until the pop.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - With occupancy 1, the new entry becomes the head in the next cycle.
- Full buffer: in_ready=0 and no push. in_valid is ignored; execute must hold.
- Status counters:
  - On each push with exc=1: ovf_sticky<=1 and ovf_count<=ovf_count+1, saturating at all-ones.
  - clear_status with an exc push in the same cycle: the event wins. Result is sticky=1, count=1.
  - clear_status alone: sticky=0, count=0.
- Reset (asynchronous, active-low), applicable at any time including mid-drain:
  - Buffer emptied and occupancy=0.
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - ovf_sticky=0, ovf_count=0.
  - in_ready=1 from the first clock after reset deasserts.
  - In-flight results are discarded.

Decomposition:
- Shared package:
  - opcode constants: OP_RTYPE=00000, OP_ADDI=00101.
  - rstatus code constants.
  - STATUS_REG default.
- One natural sub-module: wb_fifo2, the 2-entry FIFO with registered head and occupancy count, parameterised on entry width.
- Classification and counters remain in the top module.

Test Plan:
- Reset mid-operation: fill buffer with rf_ready=0, assert reset → ctrl_writeEnable=0, ovf_count=0, in_ready=1 after release, no stale write appears.
- Normal add: opcode 00000, rd=5, alu_result=0x00000007, check_ovf=0, rf_ready=1 → next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=7, for one cycle.
- Qualified overflow sub: check_ovf=1, overflow=1, rstatus=3, rd=4 → ctrl_writeReg=30, data_writeReg=0x00000003, ovf_sticky=1, ovf_count=1, no write to r4.
- Back-pressure: rf_ready=0, push 3 results on consecutive cycles → in_ready drops after 2 pushes, outputs hold first result; raise rf_ready → writes retire in order, one per cycle.
- Suppressed writes: rd=0 add, then opcode 01000 → no ctrl_writeEnable pulse, both drain in 1 cycle each even with rf_ready=0.
- Counter corner cases: CNT_W=2, five qualified overflows → ovf_count saturates at 3; clear_status coincident with a sixth → sticky=1, count=1.
